// File: rtl/vault_pkg.sv
// Shared constants for the vault auto-solver: unlock symbol tables and the
// solver state encoding.
package vault_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CODE,
    ST_SWITCH,
    ST_MAZE,
    ST_PLATES,
    ST_WAIT_DONE,
    ST_RECOVER,
    ST_DONE,
    ST_FAIL
  } state_t;

  localparam int CODE_LEN  = 4;
  localparam int MAZE_LEN  = 5;
  localparam int PLATE_LEN = 3;

  // Tables are packed first-symbol-in-MSBs.
  localparam logic [3:0]  CODE_SEQ   = 4'b1011;
  localparam logic [3:0]  SWITCH_KEY = 4'b1101;
  localparam logic [14:0] MAZE_TAB   = {3'b000, 3'b011, 3'b001, 3'b010, 3'b000};
  localparam logic [23:0] PLATE_TAB  = {8'hAA, 8'hCC, 8'hF0};

  function automatic logic code_bit(input logic [2:0] idx);
    case (idx)
      3'd0:    code_bit = CODE_SEQ[3];
      3'd1:    code_bit = CODE_SEQ[2];
      3'd2:    code_bit = CODE_SEQ[1];
      default: code_bit = CODE_SEQ[0];
    endcase
  endfunction

  function automatic logic [2:0] maze_dir(input logic [2:0] idx);
    case (idx)
      3'd0:    maze_dir = MAZE_TAB[14:12];
      3'd1:    maze_dir = MAZE_TAB[11:9];
      3'd2:    maze_dir = MAZE_TAB[8:6];
      3'd3:    maze_dir = MAZE_TAB[5:3];
      default: maze_dir = MAZE_TAB[2:0];
    endcase
  endfunction

  function automatic logic [7:0] plate_word(input logic [2:0] idx);
    case (idx)
      3'd0:    plate_word = PLATE_TAB[23:16];
      3'd1:    plate_word = PLATE_TAB[15:8];
      default: plate_word = PLATE_TAB[7:0];
    endcase
  endfunction

endpackage

// File: rtl/vault_seq_step.sv
// Symbol sequencer: holds each index for HOLD_CYC cycles and flags the wrap
// of the final index so the owning phase can exit without an idle gap.
module vault_seq_step #(
  parameter int HOLD_CYC = 1,
  parameter int IW       = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [IW-1:0] len,
  output logic [IW-1:0] idx,
  output logic          last
);

  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  logic [HW-1:0] hold;
  logic          adv;

  assign adv  = en && (hold == HW'(HOLD_CYC - 1));
  assign last = adv && (idx == len - IW'(1));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      hold <= '0;
      idx  <= '0;
    end else if (en) begin
      if (adv) begin
        hold <= '0;
        if (!last) idx <= idx + IW'(1);
      end else begin
        hold <= hold + HW'(1);
      end
    end
  end

endmodule

// File: rtl/vault_auto_solver.sv
// Autonomous vault unlock initiator: drives code, switch, maze and plate
// phases, waits for all_done, and resets/retries the vault on alarm or timeout.
module vault_auto_solver
  import vault_pkg::*;
#(
  parameter int HOLD_CYC  = 1,
  parameter int SW_HOLD   = 2,
  parameter int TIMEOUT   = 64,
  parameter int MAX_RETRY = 2,
  parameter int VRST_CYC  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       code_out,
  output logic [3:0] switch_out,
  output logic [2:0] dir_out,
  output logic [7:0] plate_out,
  output logic       vault_reset,
  input  logic       all_done_in,
  input  logic       alarm_in,
  input  logic [1:0] time_lock_in,
  output logic       busy,
  output logic       solved,
  output logic       failed,
  output logic [1:0] retries
);

  state_t      state, state_nxt;
  logic [15:0] cyc_cnt;
  logic [2:0]  seq_idx, seq_len;
  logic        seq_en, seq_last, seq_clr;
  logic        start_ok, alarm_hit, timeout_hit, retry_ok;

  // time_lock is observed only; reduce it so the port stays connected.
  logic time_lock_unused;
  assign time_lock_unused = ^time_lock_in;

  assign busy      = !(state inside {ST_IDLE, ST_DONE, ST_FAIL});
  assign solved    = (state == ST_DONE);
  assign failed    = (state == ST_FAIL);
  assign start_ok  = start && !busy;
  assign alarm_hit = alarm_in && busy && (state != ST_RECOVER);
  // Fires on the last WAIT_DONE cycle so RECOVER starts exactly TIMEOUT cycles in.
  assign timeout_hit = (state == ST_WAIT_DONE) && (cyc_cnt == 16'(TIMEOUT - 1));
  assign retry_ok    = int'(retries) < MAX_RETRY;
  assign seq_clr     = (state_nxt != state);

  vault_seq_step #(.HOLD_CYC(HOLD_CYC), .IW(3)) u_seq (
    .clk   (clk),
    .reset (reset),
    .clr   (seq_clr),
    .en    (seq_en),
    .len   (seq_len),
    .idx   (seq_idx),
    .last  (seq_last)
  );

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_nxt   = state;
    seq_en      = 1'b0;
    seq_len     = 3'(CODE_LEN);
    code_out    = 1'b0;
    switch_out  = '0;
    dir_out     = '0;
    plate_out   = '0;
    vault_reset = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) state_nxt = ST_CODE;
      end
      ST_CODE: begin
        seq_en   = 1'b1;
        code_out = code_bit(seq_idx);
        if (seq_last) state_nxt = ST_SWITCH;
      end
      ST_SWITCH: begin
        switch_out = SWITCH_KEY;
        if (cyc_cnt == 16'(SW_HOLD - 1)) state_nxt = ST_MAZE;
      end
      ST_MAZE: begin
        seq_en     = 1'b1;
        seq_len    = 3'(MAZE_LEN);
        switch_out = SWITCH_KEY;
        dir_out    = maze_dir(seq_idx);
        if (seq_last) state_nxt = ST_PLATES;
      end
      ST_PLATES: begin
        seq_en     = 1'b1;
        seq_len    = 3'(PLATE_LEN);
        switch_out = SWITCH_KEY;
        plate_out  = plate_word(seq_idx);
        if (seq_last) state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        switch_out = SWITCH_KEY;
        plate_out  = PLATE_TAB[7:0];
        if (all_done_in) state_nxt = ST_DONE;
      end
      ST_RECOVER: begin
        vault_reset = 1'b1;
        if (cyc_cnt == 16'(VRST_CYC - 1)) state_nxt = ST_CODE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Alarm or timeout overrides any phase progress, including all_done.
    if (alarm_hit || timeout_hit) state_nxt = retry_ok ? ST_RECOVER : ST_FAIL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cyc_cnt <= '0;
      retries <= '0;
    end else begin
      state   <= state_nxt;
      cyc_cnt <= (state_nxt != state) ? 16'd0 : cyc_cnt + 16'd1;
      if (start_ok)
        retries <= '0;
      else if ((alarm_hit || timeout_hit) && retry_ok && (retries != 2'd3))
        retries <= retries + 2'd1;
    end
  end

endmodule
